// File: rtl/ihp_sram_port_responder_pkg.sv
// ---------------------------------------------------------------------------
// ihp_sram_resp_pkg
// Shared constants and types for the IHP SRAM port responder:
//   DEF_ADDR_W / DEF_DATA_W : default address and data widths
//   CNT_W                   : width of the optional access counters
//   sram_state_t, ST_*      : FSM state type and state encodings
//   sat_inc()               : saturating increment used by the counters
// ---------------------------------------------------------------------------
package ihp_sram_resp_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;
    localparam int CNT_W      = 16;

    typedef logic [0:0] sram_state_t;

    localparam sram_state_t ST_CLEAR = 1'b0;
    localparam sram_state_t ST_READY = 1'b1;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        logic [CNT_W-1:0] res;
        if (val == {CNT_W{1'b1}}) begin
            res = val;
        end else begin
            res = val + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

endpackage

// File: rtl/ihp_sram_port_responder_if.sv
// ---------------------------------------------------------------------------
// ihp_sram_port_responder_if
// SRAM-style port bundle between a requester (master) and the responder
// (slave).
//   ADDR_SRAM  word address           DIN_SRAM  write data
//   BM_SRAM    per-bit write mask     WEN/MEN/REN_SRAM write/macro/read enables
//   DOUT_SRAM  registered read data   BUSY      clear sweep in progress
// ---------------------------------------------------------------------------
interface ihp_sram_port_responder_if
    import ihp_sram_resp_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic [ADDR_W-1:0] ADDR_SRAM;
    logic [DATA_W-1:0] DIN_SRAM;
    logic [DATA_W-1:0] BM_SRAM;
    logic              WEN_SRAM;
    logic              MEN_SRAM;
    logic              REN_SRAM;
    logic [DATA_W-1:0] DOUT_SRAM;
    logic              BUSY;

    modport master (
        output ADDR_SRAM, DIN_SRAM, BM_SRAM, WEN_SRAM, MEN_SRAM, REN_SRAM,
        input  DOUT_SRAM, BUSY
    );

    modport slave (
        input  ADDR_SRAM, DIN_SRAM, BM_SRAM, WEN_SRAM, MEN_SRAM, REN_SRAM,
        output DOUT_SRAM, BUSY
    );

endinterface

// File: rtl/ihp_sram_resp_array.sv
// ---------------------------------------------------------------------------
// ihp_sram_resp_array
// Single-port storage with bit-masked write and registered read.
//   i_clk, i_rst_n : clock, async active-low reset (read register only)
//   i_we, i_re     : write / read strobes for this cycle
//   i_addr         : word address
//   i_din, i_bm    : write data and mask (1 = write that bit)
//   o_dout         : read data, updated the edge after i_re; on a combined
//                    write+read it returns the freshly merged word
// ---------------------------------------------------------------------------
module ihp_sram_resp_array #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_din,
    input  logic [DATA_W-1:0] i_bm,
    output logic [DATA_W-1:0] o_dout
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [DATA_W-1:0] r_dout;
    logic [DATA_W-1:0] w_old;
    logic [DATA_W-1:0] w_merged;

    // Current word and its masked merge with the incoming data.
    always_comb begin
        w_old    = r_mem[i_addr];
        w_merged = (i_din & i_bm) | (w_old & ~i_bm);
    end

    // Storage update; contents are defined by the clear sweep, not by reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= w_merged;
        end
    end

    // Registered read port with write-through of the merged word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dout <= {DATA_W{1'b0}};
        end else if (i_re) begin
            r_dout <= i_we ? w_merged : w_old;
        end else begin
            r_dout <= r_dout;
        end
    end

    assign o_dout = r_dout;

endmodule

// File: rtl/ihp_sram_port_responder.sv
// ---------------------------------------------------------------------------
// ihp_sram_port_responder
// SRAM port responder: after reset it zeroes every word (CLEAR, one address
// per cycle, BUSY high), then serves masked writes and 1-cycle-latency reads
// (READY).
//   UserCLK  : clock (rising edge)
//   resetn   : async active-low reset; restarts the clear sweep
//   bus      : slave side of ihp_sram_port_responder_if
//   RD_CNT / WR_CNT : saturating accepted-read / accepted-write counters,
//                     present only when SRAM_RESP_ACCESS_CNT_EN is defined
// ---------------------------------------------------------------------------
module ihp_sram_port_responder
    import ihp_sram_resp_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                       UserCLK,
    input  logic                       resetn,
    ihp_sram_port_responder_if.slave   bus
`ifdef SRAM_RESP_ACCESS_CNT_EN
    ,
    output logic [CNT_W-1:0]           RD_CNT,
    output logic [CNT_W-1:0]           WR_CNT
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    sram_state_t       r_state;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic              r_busy;

    logic              w_acc_rd;
    logic              w_acc_wr;
    logic              w_arr_we;
    logic              w_arr_re;
    logic [ADDR_W-1:0] w_arr_addr;
    logic [DATA_W-1:0] w_arr_din;
    logic [DATA_W-1:0] w_arr_bm;
    logic [DATA_W-1:0] w_dout;

    // Enable decode: the sweep owns the array in CLEAR, the port in READY.
    always_comb begin
        w_acc_rd   = 1'b0;
        w_acc_wr   = 1'b0;
        w_arr_we   = 1'b0;
        w_arr_re   = 1'b0;
        w_arr_addr = {ADDR_W{1'b0}};
        w_arr_din  = {DATA_W{1'b0}};
        w_arr_bm   = {DATA_W{1'b0}};
        if (r_state == ST_CLEAR) begin
            w_arr_we   = 1'b1;
            w_arr_re   = 1'b0;
            w_arr_addr = r_clr_ptr;
            w_arr_din  = {DATA_W{1'b0}};
            w_arr_bm   = {DATA_W{1'b1}};
        end else begin
            // REN with WEN is write-through, so it still counts as a read.
            w_acc_rd   = bus.MEN_SRAM & bus.REN_SRAM;
            w_acc_wr   = bus.MEN_SRAM & bus.WEN_SRAM;
            w_arr_we   = w_acc_wr;
            w_arr_re   = w_acc_rd;
            w_arr_addr = bus.ADDR_SRAM;
            w_arr_din  = bus.DIN_SRAM;
            w_arr_bm   = bus.BM_SRAM;
        end
    end

    // CLEAR/READY state machine with the sweep pointer and BUSY flag.
    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= {ADDR_W{1'b0}};
            r_busy    <= 1'b1;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
                    if (r_clr_ptr == LAST_ADDR) begin
                        r_state <= ST_READY;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_CLEAR;
                        r_busy  <= 1'b1;
                    end
                end
                ST_READY: begin
                    r_state   <= ST_READY;
                    r_clr_ptr <= r_clr_ptr;
                    r_busy    <= 1'b0;
                end
                default: begin
                    r_state   <= ST_CLEAR;
                    r_clr_ptr <= {ADDR_W{1'b0}};
                    r_busy    <= 1'b1;
                end
            endcase
        end
    end

    ihp_sram_resp_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .i_clk   (UserCLK),
        .i_rst_n (resetn),
        .i_we    (w_arr_we),
        .i_re    (w_arr_re),
        .i_addr  (w_arr_addr),
        .i_din   (w_arr_din),
        .i_bm    (w_arr_bm),
        .o_dout  (w_dout)
    );

    assign bus.DOUT_SRAM = w_dout;
    assign bus.BUSY      = r_busy;

`ifdef SRAM_RESP_ACCESS_CNT_EN
    logic [CNT_W-1:0] r_rd_cnt;
    logic [CNT_W-1:0] r_wr_cnt;

    // Saturating counters of accepted accesses; idle during CLEAR by decode.
    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            r_rd_cnt <= {CNT_W{1'b0}};
            r_wr_cnt <= {CNT_W{1'b0}};
        end else begin
            if (w_acc_rd) begin
                r_rd_cnt <= sat_inc(r_rd_cnt);
            end else begin
                r_rd_cnt <= r_rd_cnt;
            end
            if (w_acc_wr) begin
                r_wr_cnt <= sat_inc(r_wr_cnt);
            end else begin
                r_wr_cnt <= r_wr_cnt;
            end
        end
    end

    assign RD_CNT = r_rd_cnt;
    assign WR_CNT = r_wr_cnt;
`endif

endmodule

// File: tb/tb_ihp_sram_port_responder.sv
// ---------------------------------------------------------------------------
// tb_ihp_sram_port_responder
// Self-checking bench for ihp_sram_port_responder. Directed scenarios plus a
// randomized phase, all compared against a word-array reference model.
// Counter checks are compiled in when SRAM_RESP_ACCESS_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_ihp_sram_port_responder;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    ihp_sram_port_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef SRAM_RESP_ACCESS_CNT_EN
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;
`endif

    ihp_sram_port_responder #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .UserCLK (clk),
        .resetn  (rstn),
        .bus     (bus)
`ifdef SRAM_RESP_ACCESS_CNT_EN
        ,
        .RD_CNT  (rd_cnt),
        .WR_CNT  (wr_cnt)
`endif
    );

    int n_err = 0;
    int n_chk = 0;

    // Reference model
    logic [31:0] m_mem [0:DEPTH-1];
    logic [31:0] m_dout;
    int          m_rd;
    int          m_wr;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic men, input logic wen, input logic ren,
                          input logic [AW-1:0] addr, input logic [31:0] din,
                          input logic [31:0] bm);
        bus.MEN_SRAM  = men;
        bus.WEN_SRAM  = wen;
        bus.REN_SRAM  = ren;
        bus.ADDR_SRAM = addr;
        bus.DIN_SRAM  = din;
        bus.BM_SRAM   = bm;
    endtask

    task automatic idle();
        set_in(1'b0, 1'b0, 1'b0, 10'd0, 32'd0, 32'd0);
    endtask

    task automatic model_reset();
        m_dout = 32'd0;
        m_rd   = 0;
        m_wr   = 0;
    endtask

    task automatic check_counters(input string tag);
`ifdef SRAM_RESP_ACCESS_CNT_EN
        check_val({tag, "_rdcnt"}, {16'd0, rd_cnt}, m_rd);
        check_val({tag, "_wrcnt"}, {16'd0, wr_cnt}, m_wr);
`endif
    endtask

    // One READY-state cycle: drive, clock, advance model, compare.
    task automatic access(input logic men, input logic wen, input logic ren,
                          input logic [AW-1:0] addr, input logic [31:0] din,
                          input logic [31:0] bm, input string tag);
        logic [31:0] new_word;
        set_in(men, wen, ren, addr, din, bm);
        tick();
        new_word = (din & bm) | (m_mem[addr] & ~bm);
        if (men && ren) m_dout = wen ? new_word : m_mem[addr];
        if (men && wen) m_mem[addr] = new_word;
        if (men && ren && m_rd < 65535) m_rd++;
        if (men && wen && m_wr < 65535) m_wr++;
        check_val(tag, bus.DOUT_SRAM, m_dout);
    endtask

    // Follows a reset release: count BUSY cycles, poke a write mid-sweep.
    task automatic sweep(input string tag);
        int   n;
        logic dout_bad;
        n        = 0;
        dout_bad = 1'b0;
        idle();
        while (bus.BUSY === 1'b1 && n < 2000) begin
            if (n == 600) set_in(1'b1, 1'b1, 1'b1, 10'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            else if (n == 601) idle();
            tick();
            n++;
            if (bus.DOUT_SRAM !== 32'd0) dout_bad = 1'b1;
        end
        idle();
        check_val({tag, "_busy_cycles"}, n, 32'd1024);
        check_val({tag, "_busy_low"}, {31'd0, bus.BUSY}, 32'd0);
        check_val({tag, "_dout_zero"}, {31'd0, dout_bad}, 32'd0);
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;
        check_counters(tag);
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_dout"}, bus.DOUT_SRAM, 32'd0);
        check_val({tag, "_busy"}, {31'd0, bus.BUSY}, 32'd1);
        check_counters(tag);
    endtask

    initial begin
        logic [AW-1:0] ra;
        idle();
        model_reset();
        rstn = 1'b0;
        repeat (3) tick();
        check_reset_state("por");
        rstn = 1'b1;
        sweep("sweep1");

        // Read right after the sweep returns zero.
        access(1'b1, 1'b0, 1'b1, 10'd5, 32'd0, 32'd0, "rd5");
        check_val("rd5_lit", bus.DOUT_SRAM, 32'd0);

        // Full write then masked write, then immediate read-back.
        access(1'b1, 1'b1, 1'b0, 10'd3, 32'hDEAD_BEEF, 32'hFFFF_FFFF, "wr3a");
        access(1'b1, 1'b1, 1'b0, 10'd3, 32'h1234_5678, 32'h0000_FFFF, "wr3b");
        access(1'b1, 1'b0, 1'b1, 10'd3, 32'd0, 32'd0, "rd3");
        check_val("rd3_lit", bus.DOUT_SRAM, 32'hDEAD_5678);

        // Write-through.
        access(1'b1, 1'b1, 1'b1, 10'd7, 32'hA5A5_A5A5, 32'hFFFF_FFFF, "wt7");
        check_val("wt7_lit", bus.DOUT_SRAM, 32'hA5A5_A5A5);
`ifdef SRAM_RESP_ACCESS_CNT_EN
        check_val("wt7_rdcnt_lit", {16'd0, rd_cnt}, 32'd3);
        check_val("wt7_wrcnt_lit", {16'd0, wr_cnt}, 32'd3);
`endif

        // DOUT holds with MEN low.
        access(1'b1, 1'b0, 1'b1, 10'd3, 32'd0, 32'd0, "rd3b");
        for (int i = 0; i < 4; i++) begin
            access(1'b0, 1'b1, 1'b1, 10'd3, $urandom, $urandom, "men0_hold");
            check_val("men0_hold_lit", bus.DOUT_SRAM, 32'hDEAD_5678);
        end
        // BM=0 write leaves the word alone; write without REN holds DOUT.
        access(1'b1, 1'b1, 1'b0, 10'd3, 32'hFFFF_FFFF, 32'd0, "bm0_wr");
        check_val("wr_noren_hold", bus.DOUT_SRAM, 32'hDEAD_5678);
        access(1'b1, 1'b0, 1'b0, 10'd7, 32'd0, 32'd0, "men1_idle");
        access(1'b1, 1'b0, 1'b1, 10'd3, 32'd0, 32'd0, "rd3c");
        check_val("rd3c_lit", bus.DOUT_SRAM, 32'hDEAD_5678);
        check_counters("directed");

        // Randomized traffic on a small address window to force collisions.
        for (int i = 0; i < 400; i++) begin
            ra = AW'($urandom_range(0, 15));
            access(1'($urandom), 1'($urandom), 1'($urandom), ra, $urandom,
                   ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom, "rand");
            check_counters("rand");
        end

        // Reset clears DOUT even mid-access.
        access(1'b1, 1'b1, 1'b1, 10'd9, 32'h0BAD_F00D, 32'hFFFF_FFFF, "pre_rst");
        set_in(1'b1, 1'b0, 1'b1, 10'd9, 32'd0, 32'd0);
        rstn = 1'b0;
        #1;
        model_reset();
        check_reset_state("rst_access");
        tick();
        idle();
        rstn = 1'b1;
        repeat (500) tick();
        check_val("mid_sweep_busy", {31'd0, bus.BUSY}, 32'd1);
        rstn = 1'b0;
        #1;
        check_reset_state("rst_sweep500");
        tick();
        rstn = 1'b1;
        sweep("sweep2");
        access(1'b1, 1'b0, 1'b1, 10'd2, 32'd0, 32'd0, "rd2_after_clear");
        check_val("rd2_lit", bus.DOUT_SRAM, 32'd0);
        access(1'b1, 1'b0, 1'b1, 10'd3, 32'd0, 32'd0, "rd3_after_clear");
        access(1'b1, 1'b0, 1'b1, 10'd9, 32'd0, 32'd0, "rd9_after_clear");

`ifdef SRAM_RESP_ACCESS_CNT_EN
        // Read counter saturation.
        set_in(1'b1, 1'b0, 1'b1, 10'd4, 32'd0, 32'd0);
        repeat (70000) tick();
        idle();
        check_val("rdcnt_sat", {16'd0, rd_cnt}, 32'h0000_FFFF);
        check_val("wrcnt_after_sat", {16'd0, wr_cnt}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ihp_sram_port_responder.md
IHP_SRAM_PORT_RESPONDER -- requirements
Module: ihp_sram_port_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, address width; depth = 2**ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 32, data and bit-mask width.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port UserCLK, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port ADDR_SRAM, input, ADDR_W, word address.
REQ-007 SHALL have port DIN_SRAM, input, DATA_W, write data.
REQ-008 SHALL have port BM_SRAM, input, DATA_W, per-bit write mask; 1 = write that bit.
REQ-009 SHALL have ports WEN_SRAM, MEN_SRAM and REN_SRAM, input, 1 each, active-high write, macro and read enables.
REQ-010 SHALL have port DOUT_SRAM, output, DATA_W, registered read data.
REQ-011 SHALL have port BUSY, output, 1, high while the post-reset clear sweep runs.

Function
REQ-012 SHALL implement FSM states CLEAR and READY.
REQ-013 SHALL enter CLEAR on reset and write zero to one address per cycle, ascending from 0.
REQ-014 SHALL move CLEAR to READY in the cycle after address 2**ADDR_W-1 is written, so CLEAR lasts exactly 2**ADDR_W cycles.
REQ-015 SHALL hold BUSY=1 in CLEAR and BUSY=0 in READY.
REQ-016 SHALL ignore all port requests in CLEAR, with no write and DOUT_SRAM unchanged.
REQ-017 SHALL perform a read in READY when MEN=1, REN=1 and WEN=0, with mem[ADDR] appearing on DOUT_SRAM after the next rising edge (1-cycle latency).
REQ-018 SHALL perform a write in READY when MEN=1 and WEN=1, setting mem[ADDR] = (DIN & BM) | (old & ~BM); BM=0 leaves the word unchanged.
REQ-019 SHALL treat MEN=1, WEN=1, REN=1 as write-through: memory is updated and DOUT_SRAM gets the merged new word next cycle.
REQ-020 SHALL hold DOUT_SRAM with MEN=0, or with MEN=1 and WEN=REN=0, and SHALL not modify memory in those cases.
REQ-021 SHALL hold DOUT_SRAM on a write without REN.
REQ-022 SHALL return new data from a read issued one cycle after a write to the same address, with no stale bypass hazard.

Reset
REQ-023 SHALL, while resetn=0, set DOUT_SRAM=0, BUSY=1, the clear pointer to 0 and the FSM to CLEAR.
REQ-024 SHALL, on reset mid-sweep or mid-access, abort and restart the full sweep from address 0 after release.
REQ-025 SHALL not define memory contents during reset; the sweep defines them.

Configuration
REQ-026 SHALL, with SRAM_RESP_ACCESS_CNT_EN defined, add outputs RD_CNT[15:0] and WR_CNT[15:0], counting accepted reads and writes in READY.
REQ-027 SHALL make both counters saturate at 16'hFFFF, reset to 0, and not count in CLEAR.
REQ-028 SHALL count a write-through access in both counters.
REQ-029 SHALL omit those ports and that logic when SRAM_RESP_ACCESS_CNT_EN is undefined, with all other behaviour identical.

Structure
REQ-030 SHALL place the default ADDR_W and DATA_W values, the FSM state typedef and the counter width constant in package ihp_sram_resp_pkg.
REQ-031 SHALL contain the storage array with masked write and synchronous registered read in one sub-module, ihp_sram_resp_array.
REQ-032 SHALL keep the FSM, enable decode and counters in the top module.

Verification
REQ-033 SHALL test: release reset -> BUSY=1 for exactly 1024 cycles, then 0; a read of address 5 right after -> DOUT=0.
REQ-034 SHALL test: write ADDR=3, DIN=0xDEADBEEF, BM=0xFFFFFFFF; then BM=0x0000FFFF, DIN=0x12345678; read 3 -> DOUT=0xDEAD5678 one cycle after the read.
REQ-035 SHALL test: MEN=WEN=REN=1, ADDR=7, DIN=0xA5A5A5A5, BM=all ones -> next-cycle DOUT=0xA5A5A5A5, with RD_CNT and WR_CNT each +1 when the macro is on.
REQ-036 SHALL test: read addr 3 (DOUT=0xDEAD5678), then MEN=0 with REN=1 for 4 cycles -> DOUT holds 0xDEAD5678 and memory is unchanged.
REQ-037 SHALL test: assert resetn=0 at sweep address 500, then release -> DOUT=0 and BUSY=1 for a fresh 1024 cycles, with a write during CLEAR ignored (a later read returns 0).
REQ-038 SHALL test: 70000 reads with the macro on -> RD_CNT=0xFFFF and no wrap.
